// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: size codes, FSM states, lane widths.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned BYTE_LANE_W = 2;
    localparam int unsigned HALF_LANE_W = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_ADDR,
        S_LD_DATA,
        S_RMW_ADDR,
        S_RMW_DATA,
        S_WR,
        S_RESP
    } lsu_state_e;

    // Byte accesses never trap; size 2'b11 is handled as a word.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [BYTE_LANE_W-1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != '0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-RAM signals of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]             size,
    input  logic [BYTE_LANE_W-1:0] lane,
    input  logic                   is_unsigned,
    input  logic [31:0]            word,
    input  logic [15:0]            wdata,
    output logic [31:0]            load_data,
    output logic [31:0]            merged
);
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic [HALF_LANE_W-1:0] half_lane;

    always_comb begin
        half_lane = lane[BYTE_LANE_W-1];
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = half_lane ? word[31:16] : word[15:0];

        load_data = word;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                if (half_lane == '0) merged[15:0] = wdata;
                else                 merged[31:16] = wdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores as read-modify-write on a word-write RAM.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses respond with resp_err and no memory cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);
    lsu_state_e             state_q, state_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [BYTE_LANE_W-1:0] lane_q, lane_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [31:0]            load_data, merged;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                   resp_err_q, resp_err_d;
`endif

    lsu_lane_align u_align (
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .word        (bus.mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        resp_err_d   = resp_err_q;
`endif
        unique case (state_q)
            S_IDLE: if (bus.req_valid) begin
                size_d     = bus.req_size;
                uns_d      = bus.req_unsigned;
                lane_d     = bus.req_addr[1:0];
                wdata_d    = bus.req_wdata[15:0];
                mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                if (!bus.req_we) begin
                    state_d = S_LD_ADDR;
                end else if (bus.req_size[1]) begin
                    state_d     = S_WR;
                    mem_wdata_d = bus.req_wdata;
                end else begin
                    state_d = S_RMW_ADDR;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                resp_err_d = 1'b0;
                if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                    state_d      = S_RESP;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    mem_addr_d   = mem_addr_q;
                    mem_wdata_d  = mem_wdata_q;
                end
`endif
            end
            S_LD_ADDR:  state_d = S_LD_DATA;
            S_LD_DATA: begin
                resp_rdata_d = load_data;
                state_d      = S_RESP;
            end
            S_RMW_ADDR: state_d = S_RMW_DATA;
            S_RMW_DATA: begin
                mem_wdata_d = merged;
                state_d     = S_WR;
            end
            S_WR: begin
                resp_rdata_d = '0;
                state_d      = S_RESP;
            end
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // Outputs are registered by decoding the next state.
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        mem_we_d     = (state_d == S_WR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            lane_q       <= '0;
            wdata_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a shadow-memory reference model.
module tb_load_store_unit;
    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous single-port RAM: read data appears the cycle after the address.
    logic [31:0] ram [256];
    logic [31:0] ram_rd = '0;
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
        ram_rd <= ram[bus.mem_addr[9:2]];
    end
    assign bus.mem_rdata = ram_rd;

    logic [31:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] lo);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * int'(lo);
            v = (word >> sh) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = 16 * int'(lo[1]);
            v = (word >> sh) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lo, input logic [31:0] wd);
        logic [31:0] m;
        int sh;
        if (sz[1]) return wd;
        sh = (sz == 2'd0) ? 8 * int'(lo) : 16 * int'(lo[1]);
        m  = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (word & ~m) | ((wd << sh) & m);
    endfunction

    function automatic logic model_trap(input logic [1:0] sz, input logic [1:0] lo);
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return lo[0];
        return lo != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic scramble_inputs();
        logic [31:0] r;
        r = $urandom;
        bus.req_valid    = 1'b0;
        bus.req_we       = r[0];
        bus.req_size     = r[2:1];
        bus.req_unsigned = r[3];
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},  {31'b0, bus.req_ready},  32'd1);
        check({tag, "_rvalid"}, {31'b0, bus.resp_valid}, 32'd0);
        check({tag, "_err"},    {31'b0, bus.resp_err},   32'd0);
        check({tag, "_rdata"},  bus.resp_rdata,          32'd0);
        check({tag, "_we"},     {31'b0, bus.mem_we},     32'd0);
        check({tag, "_maddr"},  bus.mem_addr,            32'd0);
        check({tag, "_mwdata"}, bus.mem_wdata,           32'd0);
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after resp_valid.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        int cyc, nwe, we_cyc, exp_lat;
        logic [31:0] exp_rd, word, new_word, w_addr, w_data, first_addr;
        logic trap;
        word     = ref_mem[addr[9:2]];
        trap     = model_trap(sz, addr[1:0]);
        new_word = model_store(word, sz, addr[1:0], wd);
        if (trap)     begin exp_lat = 1; exp_rd = '0; end
        else if (!we) begin exp_lat = 3; exp_rd = model_load(word, sz, uns, addr[1:0]); end
        else          begin exp_lat = sz[1] ? 2 : 4; exp_rd = '0; end

        check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        cyc = 1; nwe = 0; we_cyc = 0; w_addr = '0; w_data = '0; first_addr = bus.mem_addr;
        while (bus.resp_valid !== 1'b1 && cyc <= 8) begin
            if (bus.mem_we === 1'b1) begin nwe++; we_cyc = cyc; w_addr = bus.mem_addr; w_data = bus.mem_wdata; end
            @(negedge clk);
            cyc++;
        end
        if (bus.mem_we === 1'b1) nwe++;
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
        check({tag, "_err"}, {31'b0, bus.resp_err}, {31'b0, trap});
        check({tag, "_nwrites"}, nwe, (we && !trap) ? 1 : 0);
        if (!trap) check({tag, "_memaddr"}, first_addr, {addr[31:2], 2'b00});
        if (nwe == 1) begin
            check({tag, "_wecycle"}, we_cyc, exp_lat - 1);
            check({tag, "_waddr"}, w_addr, {addr[31:2], 2'b00});
            check({tag, "_wdata"}, w_data, new_word);
        end
        if (we && !trap) ref_mem[addr[9:2]] = new_word;
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] r, v;
        int nwe;
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            ram[i] = r;
            ref_mem[i] = r;
        end
        ram[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;
        rst_n = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        do_req("lb",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        do_req("lbu", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        do_req("lh",  1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        do_req("lhu", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        do_req("sb",  1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
        check("sb_result", ref_mem[4], 32'h8899_55BB);
        do_req("sw",  1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
        do_req("lw",  1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        do_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
        do_req("sw_sz3", 1'b1, 2'd3, 1'b0, 32'h24, 32'h1234_5678);
        do_req("lh_mis", 1'b0, 2'd1, 1'b1, 32'h25, 32'h0);

        // Reset during RMW_DATA of a halfword store: no write may occur.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h42; bus.req_wdata = 32'hCAFE;
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        nwe = (bus.mem_we === 1'b1) ? 1 : 0;
        @(negedge clk);
        if (bus.mem_we === 1'b1) nwe++;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (bus.mem_we === 1'b1) nwe++;
        check_idle_outputs("rst_rmw");
        check("rst_rmw_nwrites", nwe, 0);
        rst_n = 1'b1;
        do_req("rst_rmw_lw", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

        // Reset during WR: the write in that cycle lands, no response follows.
        v = $urandom;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h44; bus.req_wdata = v;
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        check("rst_wr_we", {31'b0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_wr_we_off", {31'b0, bus.mem_we}, 32'd0);
        check("rst_wr_noresp", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        check("rst_wr_noresp2", {31'b0, bus.resp_valid}, 32'd0);
        rst_n = 1'b1;
        ref_mem[17] = v;
        do_req("rst_wr_lw", 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            do_req("rand", r[0], r[2:1], r[3], {22'b0, r[13:4]}, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
